lane_note_scroller: RTL and testbench
=====================================

// Module: lane_note_scroller
// PURPOSE
//  Multi-lane successor of the single-pattern scroller.
//  - Holds up to SLOTS note rows in flight; each row is a lane bitmask plus a shared y position.
//  - Advances every row by SPEED px per frame, accepts hit presses inside a window, reports misses.
//  - Renders per-pixel lane coverage for the VGA pixel stream (next_x/next_y), one cycle after the request.
//  - Sits between the note/command source and the colour mapping that feeds the vga block.
// PARAMETERS
//  LANES     4    number of lanes (width of all lane masks)
//  SLOTS     8    note rows in flight
//  Y_W       11   y register width; must hold SCREEN_H+SPEED
//  Y_INI     0    y loaded into a row at spawn
//  SPEED     2    px added to each row per frame_tick
//  NOTE_H    16   note height in px
//  LANE_X0   160  x of lane 0 left edge
//  LANE_W    80   lane width in px
//  SCREEN_H  480  a row whose updated y >= SCREEN_H is retired as a miss
//  HIT_Y     400  hit line
//  HIT_WIN   12   hit accepted when HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN
// PORTS
//  CLOCK_25        in   1      sole clock, rising edge
//  reset           in   1      synchronous, active-high
//  frame_tick      in   1      one-cycle pulse per frame, from VGA timing
//  spawn_valid     in   1      spawn request
//  spawn_mask      in   LANES  lanes of the new row
//  spawn_ready     out  1      at least one free slot (combinational from slot state)
//  hit_valid       in   1      player press
//  hit_mask        in   LANES  lanes pressed
//  hit_ok          out  LANES  registered pulse: lanes cleared by the press
//  miss_pulse      out  1      registered pulse: one or more rows retired by scrolling
//  miss_mask       out  LANES  OR of uncleared lane bits of retired rows
//  next_x          in   10     pixel column being fetched
//  next_y          in   10     pixel row being fetched
//  sprite_pattern  out  LANES  registered lane coverage of (next_x, next_y)
//  active_rows     out  $clog2(SLOTS+1)  count of valid slots, registered
// BEHAVIOUR
//  Reset:
//  - Decided: one clock; reset is synchronous and active-high.
//  - Reset clears all slots (valid=0, mask=0, y=0) and drives every output to 0.
//  - spawn_ready is therefore 1 in the cycle after reset.
//  - Reset in mid-frame or mid-spawn discards everything; no pulses are emitted.
//  Spawn:
//  - Accepted when spawn_valid & spawn_ready & (spawn_mask!=0).
//  - Writes the lowest-index free slot: valid=1, mask=spawn_mask, y=Y_INI.
//  - spawn_mask==0 is dropped; no slot is consumed.
//  - When full (spawn_ready=0), requests are dropped; the source must hold them.
//  Hit (evaluated on pre-update state):
//  - For each valid slot with y in the window: mask &= ~hit_mask.
//  - hit_ok(t+1) = OR over those slots of (mask & hit_mask).
//  - A slot whose mask becomes 0 is freed in the same cycle.
//  - Presses with no matching note give hit_ok=0 and change no state.
//  Frame (frame_tick=1):
//  - Every slot still valid after the hit step gets y_n = y+SPEED.
//  - y_n >= SCREEN_H: slot freed; miss_pulse(t+1)=1; miss_mask(t+1) |= its remaining mask.
//  - A slot spawned in the same cycle is not advanced; it holds Y_INI.
//  - Simultaneous hit, spawn and tick apply in the order hit -> tick -> spawn.
//  - Spawn sees free slots as they were before the hit and the tick; slots freed this cycle become reusable next cycle.
//  Render:
//  - Lane L covers x when LANE_X0+L*LANE_W <= next_x < LANE_X0+(L+1)*LANE_W.
//  - sprite_pattern[L](t+1) = 1 when some valid slot has mask[L] and y <= next_y < y+NOTE_H, with next_x in lane L.
//  - Rows partially below SCREEN_H still render.
//  - Compare in Y_W+1 bits so there is no wrap-around.
//  - Latency is exactly 1 cycle.
//  Outputs:
//  - hit_ok, miss_pulse and miss_mask are high for one cycle only.
//  - active_rows reflects the state after the cycle's updates.
// TESTING
//  1 Reset held 3 cycles with spawn_valid=1 -> all outputs 0, no slot taken; spawn_ready=1 after release.
//  2 Spawn mask 4'b0101, then next_x=170,next_y=5 -> sprite_pattern=4'b0001 one cycle later; next_x=330 -> 4'b0100; next_x=250 -> 0.
//  3 Spawn 4'b0011, 200 ticks (y=400), hit_mask 4'b0001 -> hit_ok=4'b0001; second hit 4'b0010 -> hit_ok=4'b0010, active_rows back to 0.
//  4 Spawn 4'b1000, 240 ticks without hits -> on tick 240 (y_n=480) miss_pulse=1, miss_mask=4'b1000, slot freed.
//  5 Fill 8 slots -> spawn_ready=0, 9th spawn dropped, active_rows=8; tick that retires slot 0 plus spawn in same cycle -> spawn dropped, accepted next cycle into slot 0.
//  6 hit_valid, frame_tick and spawn in one cycle at y=HIT_Y+HIT_WIN -> hit clears first (hit_ok set), new row stays at Y_INI.

Source files
------------

// File: rtl/lane_note_scroller_if.sv
// Bundle of the note-scroller's control, scoring and render signals.
// master: note/command source + VGA fetch side (drives requests, reads results).
// slave : lane_note_scroller itself.
//   frame_tick     one-cycle pulse per frame
//   spawn_valid/spawn_mask/spawn_ready   new-row request and free-slot indication
//   hit_valid/hit_mask/hit_ok            player press and lanes it cleared
//   miss_pulse/miss_mask                 rows retired by scrolling
//   next_x/next_y/sprite_pattern         pixel fetch and its lane coverage
//   active_rows                          number of rows in flight
interface lane_note_scroller_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned SLOTS = 8
);
    localparam int unsigned CNT_W = $clog2(SLOTS + 1);

    logic              frame_tick;
    logic              spawn_valid;
    logic [LANES-1:0]  spawn_mask;
    logic              spawn_ready;
    logic              hit_valid;
    logic [LANES-1:0]  hit_mask;
    logic [LANES-1:0]  hit_ok;
    logic              miss_pulse;
    logic [LANES-1:0]  miss_mask;
    logic [9:0]        next_x;
    logic [9:0]        next_y;
    logic [LANES-1:0]  sprite_pattern;
    logic [CNT_W-1:0]  active_rows;

    modport master (
        output frame_tick, spawn_valid, spawn_mask, hit_valid, hit_mask, next_x, next_y,
        input  spawn_ready, hit_ok, miss_pulse, miss_mask, sprite_pattern, active_rows
    );

    modport slave (
        input  frame_tick, spawn_valid, spawn_mask, hit_valid, hit_mask, next_x, next_y,
        output spawn_ready, hit_ok, miss_pulse, miss_mask, sprite_pattern, active_rows
    );
endinterface

// File: rtl/lane_note_scroller.sv
// Multi-lane note scroller: keeps up to SLOTS note rows (lane mask + y),
// scrolls them each frame, scores presses inside the hit window, reports
// rows that fall off screen, and renders lane coverage for the pixel fetch.
// Ports:
//   CLOCK_25  sole clock, rising edge
//   reset     synchronous, active-high
//   bus       lane_note_scroller_if.slave (all request/result signals)
module lane_note_scroller #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned SLOTS    = 8,
    parameter int unsigned Y_W      = 11,
    parameter int unsigned Y_INI    = 0,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned NOTE_H   = 16,
    parameter int unsigned LANE_X0  = 160,
    parameter int unsigned LANE_W   = 80,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned HIT_Y    = 400,
    parameter int unsigned HIT_WIN  = 12
) (
    input  logic                  CLOCK_25,
    input  logic                  reset,
    lane_note_scroller_if.slave   bus
);
    localparam int unsigned YC_W   = Y_W + 1;
    localparam int unsigned CNT_W  = $clog2(SLOTS + 1);
    localparam int unsigned IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned WIN_LO = HIT_Y - HIT_WIN;
    localparam int unsigned WIN_HI = HIT_Y + HIT_WIN;

    // Slot state
    logic [SLOTS-1:0]  r_valid;
    logic [LANES-1:0]  r_mask [SLOTS];
    logic [Y_W-1:0]    r_y    [SLOTS];

    // Registered outputs
    logic [LANES-1:0]  r_hit_ok;
    logic              r_miss_pulse;
    logic [LANES-1:0]  r_miss_mask;
    logic [LANES-1:0]  r_sprite;
    logic [CNT_W-1:0]  r_active;

    // Next-state values
    logic [SLOTS-1:0]  w_valid_n;
    logic [LANES-1:0]  w_mask_n [SLOTS];
    logic [Y_W-1:0]    w_y_n    [SLOTS];
    logic [LANES-1:0]  w_hit_ok_n;
    logic              w_miss_pulse_n;
    logic [LANES-1:0]  w_miss_mask_n;
    logic [LANES-1:0]  w_sprite_n;
    logic [CNT_W-1:0]  w_active_n;

    logic              w_spawn_ready;
    logic              w_spawn_go;
    logic [IDX_W-1:0]  w_free_idx;
    logic [LANES-1:0]  w_in_lane;

    assign w_spawn_ready = ~(&r_valid);
    assign w_spawn_go    = bus.spawn_valid && w_spawn_ready && (bus.spawn_mask != '0);

    // Lowest-index free slot, taken from the state before this cycle's updates
    always_comb begin
        w_free_idx = '0;
        for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                w_free_idx = IDX_W'(s);
            end
        end
    end

    // Which lane column the fetched pixel falls in
    always_comb begin
        w_in_lane = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_in_lane[l] = (32'(bus.next_x) >= LANE_X0 + LANE_W * 32'(l)) &&
                           (32'(bus.next_x) <  LANE_X0 + LANE_W * 32'(l + 1));
        end
    end

    // Slot update in the order hit -> tick -> spawn, plus output pulses
    always_comb begin
        w_valid_n      = r_valid;
        w_hit_ok_n     = '0;
        w_miss_pulse_n = 1'b0;
        w_miss_mask_n  = '0;
        w_active_n     = '0;
        for (int s = 0; s < int'(SLOTS); s++) begin
            w_mask_n[s] = r_mask[s];
            w_y_n[s]    = r_y[s];
        end

        for (int s = 0; s < int'(SLOTS); s++) begin
            if (r_valid[s] && bus.hit_valid &&
                YC_W'(r_y[s]) >= YC_W'(WIN_LO) && YC_W'(r_y[s]) <= YC_W'(WIN_HI)) begin
                w_hit_ok_n  = w_hit_ok_n | (r_mask[s] & bus.hit_mask);
                w_mask_n[s] = r_mask[s] & ~bus.hit_mask;
                if (w_mask_n[s] == '0) begin
                    w_valid_n[s] = 1'b0;
                end
            end

            // Advance in Y_W+1 bits so a row near the bottom cannot wrap
            if (w_valid_n[s] && bus.frame_tick) begin
                if (YC_W'(r_y[s]) + YC_W'(SPEED) >= YC_W'(SCREEN_H)) begin
                    w_valid_n[s]   = 1'b0;
                    w_miss_pulse_n = 1'b1;
                    w_miss_mask_n  = w_miss_mask_n | w_mask_n[s];
                    w_mask_n[s]    = '0;
                end else begin
                    w_y_n[s] = r_y[s] + Y_W'(SPEED);
                end
            end

            // The chosen slot was free before the update, so hit/tick never touched it
            if (w_spawn_go && (IDX_W'(s) == w_free_idx)) begin
                w_valid_n[s] = 1'b1;
                w_mask_n[s]  = bus.spawn_mask;
                w_y_n[s]     = Y_W'(Y_INI);
            end
        end

        for (int s = 0; s < int'(SLOTS); s++) begin
            w_active_n = w_active_n + CNT_W'(w_valid_n[s]);
        end
    end

    // Lane coverage of the fetched pixel from the current rows
    always_comb begin
        w_sprite_n = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int s = 0; s < int'(SLOTS); s++) begin
                if (w_in_lane[l] && r_valid[s] && r_mask[s][l] &&
                    YC_W'(bus.next_y) >= YC_W'(r_y[s]) &&
                    YC_W'(bus.next_y) <  YC_W'(r_y[s]) + YC_W'(NOTE_H)) begin
                    w_sprite_n[l] = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_valid      <= '0;
            r_hit_ok     <= '0;
            r_miss_pulse <= 1'b0;
            r_miss_mask  <= '0;
            r_sprite     <= '0;
            r_active     <= '0;
            for (int s = 0; s < int'(SLOTS); s++) begin
                r_mask[s] <= '0;
                r_y[s]    <= '0;
            end
        end else begin
            r_valid      <= w_valid_n;
            r_hit_ok     <= w_hit_ok_n;
            r_miss_pulse <= w_miss_pulse_n;
            r_miss_mask  <= w_miss_mask_n;
            r_sprite     <= w_sprite_n;
            r_active     <= w_active_n;
            for (int s = 0; s < int'(SLOTS); s++) begin
                r_mask[s] <= w_mask_n[s];
                r_y[s]    <= w_y_n[s];
            end
        end
    end

    assign bus.spawn_ready    = w_spawn_ready;
    assign bus.hit_ok         = r_hit_ok;
    assign bus.miss_pulse     = r_miss_pulse;
    assign bus.miss_mask      = r_miss_mask;
    assign bus.sprite_pattern = r_sprite;
    assign bus.active_rows    = r_active;
endmodule

// File: tb/tb_lane_note_scroller.sv
// Scoreboard bench for lane_note_scroller: each driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares them after
// the clock edge. Directed scenarios are followed by randomized traffic.
module tb_lane_note_scroller;
    localparam int LANES    = 4;
    localparam int SLOTS    = 8;
    localparam int SPEED    = 2;
    localparam int NOTE_H   = 16;
    localparam int LANE_X0  = 160;
    localparam int LANE_W   = 80;
    localparam int SCREEN_H = 480;
    localparam int HIT_Y    = 400;
    localparam int HIT_WIN  = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lane_note_scroller_if #(.LANES(LANES), .SLOTS(SLOTS)) bus ();

    lane_note_scroller #(.LANES(LANES), .SLOTS(SLOTS)) dut (
        .CLOCK_25 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        logic       rst;
        logic       tick;
        logic       sv;
        logic [3:0] sm;
        logic       hv;
        logic [3:0] hm;
        int         nx;
        int         ny;
    } stim_t;

    typedef struct {
        logic [3:0] hit_ok;
        logic       miss;
        logic [3:0] miss_mask;
        logic [3:0] sprite;
        int         active;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   m_mask[$];
    int   m_y[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.tick = 1'b0; s.sv = 1'b0; s.sm = 4'h0;
        s.hv = 1'b0; s.hm = 4'h0; s.nx = 0; s.ny = 0;
        return s;
    endfunction

    // Reference model: rows kept as an unordered list with a capacity of SLOTS
    task automatic model_step(input stim_t s, output exp_t e);
        int  nm[$];
        int  nyq[$];
        bit  room;
        int  msk;
        int  y;
        e.hit_ok = 4'h0; e.miss = 1'b0; e.miss_mask = 4'h0; e.sprite = 4'h0;
        e.active = 0; e.ready = 1'b1;
        if (s.rst) begin
            m_mask.delete();
            m_y.delete();
            return;
        end
        for (int l = 0; l < LANES; l++) begin
            if (s.nx >= LANE_X0 + l * LANE_W && s.nx < LANE_X0 + (l + 1) * LANE_W) begin
                foreach (m_mask[i]) begin
                    if (m_mask[i][l] && s.ny >= m_y[i] && s.ny < m_y[i] + NOTE_H)
                        e.sprite[l] = 1'b1;
                end
            end
        end
        room = (m_mask.size() < SLOTS);
        foreach (m_mask[i]) begin
            msk = m_mask[i];
            y   = m_y[i];
            if (s.hv && y >= HIT_Y - HIT_WIN && y <= HIT_Y + HIT_WIN) begin
                e.hit_ok = e.hit_ok | 4'(msk & int'(s.hm));
                msk = msk & ~int'(s.hm) & 15;
            end
            if (msk != 0) begin
                if (s.tick) y = y + SPEED;
                if (y >= SCREEN_H) begin
                    e.miss      = 1'b1;
                    e.miss_mask = e.miss_mask | 4'(msk);
                end else begin
                    nm.push_back(msk);
                    nyq.push_back(y);
                end
            end
        end
        if (s.sv && room && s.sm != 4'h0) begin
            nm.push_back(int'(s.sm));
            nyq.push_back(0);
        end
        m_mask   = nm;
        m_y      = nyq;
        e.active = m_mask.size();
        e.ready  = (m_mask.size() < SLOTS);
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset           = s.rst;
        bus.frame_tick  = s.tick;
        bus.spawn_valid = s.sv;
        bus.spawn_mask  = s.sm;
        bus.hit_valid   = s.hv;
        bus.hit_mask    = s.hm;
        bus.next_x      = 10'(s.nx);
        bus.next_y      = 10'(s.ny);
        model_step(s, e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic run_ticks(input int n);
        stim_t s;
        s = idle();
        s.tick = 1'b1;
        repeat (n) drive(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        drive(s);
    endtask

    task automatic spawn(input logic [3:0] m);
        stim_t s;
        s = idle();
        s.sv = 1'b1;
        s.sm = m;
        drive(s);
    endtask

    // Monitor: every driven cycle has one expected entry
    initial begin : monitor
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                check("hit_ok",      32'(bus.hit_ok),         32'(me.hit_ok));
                check("miss_pulse",  32'(bus.miss_pulse),     32'(me.miss));
                check("miss_mask",   32'(bus.miss_mask),      32'(me.miss_mask));
                check("sprite",      32'(bus.sprite_pattern), 32'(me.sprite));
                check("active_rows", 32'(bus.active_rows),    32'(me.active));
                check("spawn_ready", 32'(bus.spawn_ready),    32'(me.ready));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        stim_t s;
        int    k;
        bus.frame_tick = 1'b0; bus.spawn_valid = 1'b0; bus.spawn_mask = 4'h0;
        bus.hit_valid = 1'b0; bus.hit_mask = 4'h0; bus.next_x = 10'd0; bus.next_y = 10'd0;

        // Reset held with a spawn request pending
        s = idle(); s.rst = 1'b1; s.sv = 1'b1; s.sm = 4'hF;
        repeat (3) begin
            drive(s);
            check("t1_active_in_rst", 32'(bus.active_rows), 32'd0);
            check("t1_miss_in_rst",   32'(bus.miss_pulse),  32'd0);
        end
        drive(idle());
        check("t1_ready_after", 32'(bus.spawn_ready), 32'd1);
        check("t1_active_after", 32'(bus.active_rows), 32'd0);

        // Render of a fresh 0101 row
        spawn(4'b0101);
        check("t2_active", 32'(bus.active_rows), 32'd1);
        s = idle(); s.nx = 170; s.ny = 5; drive(s);
        check("t2_lane0", 32'(bus.sprite_pattern), 32'b0001);
        s.nx = 330; drive(s);
        check("t2_lane2", 32'(bus.sprite_pattern), 32'b0100);
        s.nx = 250; drive(s);
        check("t2_lane1", 32'(bus.sprite_pattern), 32'b0000);

        // Two presses clear a 0011 row at the hit line
        do_reset();
        spawn(4'b0011);
        run_ticks(200);
        s = idle(); s.hv = 1'b1; s.hm = 4'b0001; drive(s);
        check("t3_hit1", 32'(bus.hit_ok), 32'b0001);
        s.hm = 4'b0010; drive(s);
        check("t3_hit2", 32'(bus.hit_ok), 32'b0010);
        check("t3_active", 32'(bus.active_rows), 32'd0);

        // Unplayed row scrolls off
        do_reset();
        spawn(4'b1000);
        run_ticks(239);
        check("t4_no_miss_yet", 32'(bus.miss_pulse), 32'd0);
        run_ticks(1);
        check("t4_miss", 32'(bus.miss_pulse), 32'd1);
        check("t4_miss_mask", 32'(bus.miss_mask), 32'b1000);
        check("t4_freed", 32'(bus.active_rows), 32'd0);
        drive(idle());
        check("t4_pulse_once", 32'(bus.miss_pulse), 32'd0);

        // Full table and slot reuse timing
        do_reset();
        spawn(4'b0001);
        run_ticks(239);
        for (int i = 0; i < 7; i++) spawn(4'(i + 2));
        check("t5_full_ready", 32'(bus.spawn_ready), 32'd0);
        check("t5_full_active", 32'(bus.active_rows), 32'd8);
        spawn(4'b1111);
        check("t5_dropped", 32'(bus.active_rows), 32'd8);
        s = idle(); s.tick = 1'b1; s.sv = 1'b1; s.sm = 4'b1010; drive(s);
        check("t5_retire_miss", 32'(bus.miss_pulse), 32'd1);
        check("t5_retire_active", 32'(bus.active_rows), 32'd7);
        spawn(4'b1010);
        check("t5_reuse", 32'(bus.active_rows), 32'd8);

        // Hit, tick and spawn together at the bottom edge of the window
        do_reset();
        spawn(4'b0110);
        run_ticks(206);
        s = idle(); s.hv = 1'b1; s.hm = 4'b0110; s.tick = 1'b1; s.sv = 1'b1; s.sm = 4'b0001;
        drive(s);
        check("t6_hit", 32'(bus.hit_ok), 32'b0110);
        check("t6_active", 32'(bus.active_rows), 32'd1);
        s = idle(); s.nx = 170; s.ny = 15; drive(s);
        check("t6_at_yini", 32'(bus.sprite_pattern), 32'b0001);
        s.ny = 16; drive(s);
        check("t6_below_note", 32'(bus.sprite_pattern), 32'b0000);

        // Randomized traffic
        do_reset();
        repeat (4000) begin
            s = idle();
            s.rst  = ($urandom_range(0, 1999) == 0);
            s.tick = ($urandom_range(0, 9) < 8);
            s.sv   = ($urandom_range(0, 14) == 0);
            s.sm   = 4'($urandom);
            s.hv   = ($urandom_range(0, 3) == 0);
            s.hm   = 4'($urandom);
            s.nx   = $urandom_range(0, 639);
            if (m_y.size() > 0 && $urandom_range(0, 1) == 1) begin
                k    = $urandom_range(0, m_y.size() - 1);
                s.ny = m_y[k] + $urandom_range(0, 17) - 1;
                if (s.ny < 0) s.ny = 0;
            end else begin
                s.ny = $urandom_range(0, 479);
            end
            drive(s);
        end

        drive(idle());
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
